// File: rtl/vrased_pkg.sv
// Shared constants for the VRASED hardware-monitor reset sequencer.
package vrased_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_WAIT_PC = 2'd2;

  localparam int unsigned SRC_XSTACK     = 0;
  localparam int unsigned SRC_AC         = 1;
  localparam int unsigned SRC_ATOM       = 2;
  localparam int unsigned SRC_DMA_AC     = 3;
  localparam int unsigned SRC_DMA_DET    = 4;
  localparam int unsigned SRC_DMA_XSTACK = 5;

  localparam logic [15:0] DEFAULT_RESET_HANDLER = 16'h0000;

endpackage

// File: rtl/vrased_prio_enc.sv
// Lowest-index-first priority encoder over the violation sources.
module vrased_prio_enc #(
  parameter int unsigned NUM_SRC = 6
) (
  input  logic [NUM_SRC-1:0] vec,
  output logic [2:0]         idx,
  output logic               valid
);

  always_comb begin
    idx   = '0;
    valid = |vec;
    // Scan downward so the lowest set index is the last one written.
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (vec[i-1]) idx = 3'(i - 1);
    end
  end

endmodule

// File: rtl/vrased_reset_seq.sv
// Stretches monitor violations into a registered core reset and keeps
// sticky cause / first-cause / episode-count / attestation-abort status.
module vrased_reset_seq
  import vrased_pkg::*;
#(
  parameter int unsigned NUM_SRC       = 6,
  parameter int unsigned RESET_CYCLES  = 4,
  parameter logic [15:0] RESET_HANDLER = DEFAULT_RESET_HANDLER
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] viol_vec,
  input  logic [15:0]        pc,
  input  logic               swatt_exec,
  input  logic               cause_clr,
  output logic               reset_out,
  output logic               busy,
  output logic [NUM_SRC-1:0] cause,
  output logic [2:0]         first_cause,
  output logic               first_valid,
  output logic [7:0]         viol_count,
  output logic               attest_abort
);

  localparam logic [7:0] HOLD_LOAD = 8'(RESET_CYCLES - 1);

  logic [1:0] state;
  logic [7:0] hold_cnt;
  logic       any_viol;
  logic       start_ep;
  logic       do_clr;
  logic [2:0] enc_idx;
  logic       enc_valid;

  vrased_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
    .vec   (viol_vec),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign any_viol = |viol_vec;
  assign start_ep = any_viol && (state == ST_IDLE || state == ST_WAIT_PC);
  assign do_clr   = cause_clr && !any_viol && (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      reset_out <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_WAIT_PC: begin
          if (any_viol) begin
            state     <= ST_HOLD;
            reset_out <= 1'b1;
            hold_cnt  <= HOLD_LOAD;
          end else if (state == ST_WAIT_PC && pc == RESET_HANDLER) begin
            state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (any_viol) begin
            hold_cnt <= HOLD_LOAD;
          end else if (hold_cnt == '0) begin
            state     <= ST_WAIT_PC;
            reset_out <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: begin
          state     <= ST_HOLD;
          reset_out <= 1'b1;
          hold_cnt  <= HOLD_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause        <= '0;
      first_cause  <= '0;
      first_valid  <= 1'b0;
      viol_count   <= '0;
      attest_abort <= 1'b0;
    end else begin
      if (any_viol) cause <= cause | viol_vec;
      if (any_viol && swatt_exec) attest_abort <= 1'b1;
      if (start_ep) begin
        if (viol_count != 8'hFF) viol_count <= viol_count + 8'd1;
        if (!first_valid && enc_valid) begin
          first_cause <= enc_idx;
          first_valid <= 1'b1;
        end
      end
      // Clear is only reachable with no violation, so it never races a set.
      if (do_clr) begin
        cause        <= '0;
        first_cause  <= '0;
        first_valid  <= 1'b0;
        attest_abort <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vrased_reset_seq.sv
// Vector-table and scoreboard bench for the VRASED reset sequencer.
module tb_vrased_reset_seq;

  localparam logic [15:0] H = 16'h1234;

  typedef struct packed {
    logic       ro;
    logic       busy;
    logic [5:0] cause;
    logic [2:0] fc;
    logic       fv;
    logic [7:0] cnt;
    logic       ab;
  } outs_t;

  typedef struct {
    logic [5:0]  viol;
    logic [15:0] pc;
    logic        sw;
    logic        clr;
    outs_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  viol_vec = '0;
  logic [15:0] pc = H;
  logic        swatt_exec = 1'b0;
  logic        cause_clr = 1'b0;
  logic        reset_out, busy, first_valid, attest_abort;
  logic [5:0]  cause;
  logic [2:0]  first_cause;
  logic [7:0]  viol_count;

  int checks = 0;
  int failures = 0;
  vec_t  tbl[$];
  outs_t exp_q[$];

  vrased_reset_seq #(.NUM_SRC(6), .RESET_CYCLES(4), .RESET_HANDLER(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .viol_vec(viol_vec), .pc(pc),
    .swatt_exec(swatt_exec), .cause_clr(cause_clr), .reset_out(reset_out),
    .busy(busy), .cause(cause), .first_cause(first_cause),
    .first_valid(first_valid), .viol_count(viol_count), .attest_abort(attest_abort)
  );

  always #5 clk = ~clk;

  function automatic outs_t cur();
    outs_t o;
    o = '{reset_out, busy, cause, first_cause, first_valid, viol_count, attest_abort};
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic [5:0] v, input logic [15:0] p, input logic s, input logic c,
                     input logic ro, input logic b, input logic [5:0] ca, input logic [2:0] fc,
                     input logic fv, input logic [7:0] n, input logic ab);
    vec_t r;
    r.viol = v; r.pc = p; r.sw = s; r.clr = c;
    r.exp = '{ro, b, ca, fc, fv, n, ab};
    tbl.push_back(r);
  endtask

  // Drive one cycle, queue the expectation, pop and compare after the edge.
  task automatic step(input logic [5:0] v, input logic [15:0] p, input logic s, input logic c,
                      input outs_t e, input string name);
    outs_t want;
    viol_vec = v; pc = p; swatt_exec = s; cause_clr = c;
    exp_q.push_back(e);
    @(posedge clk); #1;
    want = exp_q.pop_front();
    check(name, 32'(cur()), 32'(want));
  endtask

  initial begin
    // single-source episode, restart, clear
    add(6'b000100, H, 0, 0, 1, 1, 6'b000100, 2, 1, 1, 0);
    repeat (3) add(0, H, 0, 0, 1, 1, 6'b000100, 2, 1, 1, 0);
    add(0, H, 0, 0, 0, 1, 6'b000100, 2, 1, 1, 0);
    add(0, H, 0, 0, 0, 1, 6'b000100, 2, 1, 1, 0);
    add(0, 16'h0000, 0, 0, 0, 0, 6'b000100, 2, 1, 1, 0);
    add(0, H, 0, 1, 0, 0, 6'b000000, 0, 0, 1, 0);
    // re-arm on the third HOLD cycle: 7 cycles of reset
    add(6'b010010, H, 0, 0, 1, 1, 6'b010010, 1, 1, 2, 0);
    repeat (2) add(0, H, 0, 0, 1, 1, 6'b010010, 1, 1, 2, 0);
    add(6'b000001, H, 0, 0, 1, 1, 6'b010011, 1, 1, 2, 0);
    repeat (3) add(0, H, 0, 0, 1, 1, 6'b010011, 1, 1, 2, 0);
    add(0, H, 0, 0, 0, 1, 6'b010011, 1, 1, 2, 0);
    // violation beats pc==handler in WAIT_PC
    add(6'b001000, 16'h0000, 0, 0, 1, 1, 6'b011011, 1, 1, 3, 0);
    repeat (3) add(0, H, 0, 0, 1, 1, 6'b011011, 1, 1, 3, 0);
    add(0, H, 0, 0, 0, 1, 6'b011011, 1, 1, 3, 0);
    add(0, 16'h0000, 0, 0, 0, 0, 6'b011011, 1, 1, 3, 0);
    // attest abort, clear ignored in HOLD, honoured in IDLE
    add(0, H, 0, 1, 0, 0, 6'b000000, 0, 0, 3, 0);
    add(6'b100000, H, 1, 0, 1, 1, 6'b100000, 5, 1, 4, 1);
    add(0, H, 0, 1, 1, 1, 6'b100000, 5, 1, 4, 1);
    repeat (2) add(0, H, 0, 0, 1, 1, 6'b100000, 5, 1, 4, 1);
    add(0, H, 0, 0, 0, 1, 6'b100000, 5, 1, 4, 1);
    add(0, 16'h0000, 0, 0, 0, 0, 6'b100000, 5, 1, 4, 1);
    add(0, H, 0, 1, 0, 0, 6'b000000, 0, 0, 4, 0);
    // clear together with violation: violation kept, clear dropped
    add(6'b100000, H, 0, 1, 1, 1, 6'b100000, 5, 1, 5, 0);
    repeat (3) add(0, H, 0, 0, 1, 1, 6'b100000, 5, 1, 5, 0);
    add(0, H, 0, 0, 0, 1, 6'b100000, 5, 1, 5, 0);
    add(0, 16'h0000, 1, 0, 0, 0, 6'b100000, 5, 1, 5, 0);
    // later episode keeps first_cause
    add(6'b000011, H, 0, 0, 1, 1, 6'b100011, 5, 1, 6, 0);
    repeat (3) add(0, H, 0, 0, 1, 1, 6'b100011, 5, 1, 6, 0);
    add(0, H, 0, 0, 0, 1, 6'b100011, 5, 1, 6, 0);
    add(0, 16'h0000, 0, 0, 0, 0, 6'b100011, 5, 1, 6, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(cur()), 32'(outs_t'('0)));
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].viol, tbl[i].pc, tbl[i].sw, tbl[i].clr, tbl[i].exp, $sformatf("vec%0d", i));

    // async reset in the middle of HOLD
    step(6'b000001, H, 0, 0, '{1, 1, 6'b100011, 5, 1, 7, 0}, "pre_async_hold");
    viol_vec = '0;
    reset_n = 1'b0;
    #1;
    check("async_reset_no_edge", 32'(cur()), 32'(outs_t'('0)));
    @(negedge clk);
    reset_n = 1'b1;
    step(0, H, 0, 0, '0, "post_async_idle");

    // saturation: 257 episodes, reset length unchanged once saturated
    for (int ep = 0; ep < 257; ep++) begin
      int highs;
      int guard;
      viol_vec = 6'b000010; pc = H; swatt_exec = 0; cause_clr = 0;
      @(posedge clk); #1;
      highs = reset_out ? 1 : 0;
      check($sformatf("sat_count_ep%0d", ep), 32'(viol_count), (ep + 1 > 255) ? 32'd255 : 32'(ep + 1));
      viol_vec = '0; pc = 16'h0000;
      guard = 0;
      while (busy && guard < 20) begin
        @(posedge clk); #1;
        if (reset_out) highs++;
        guard++;
      end
      check($sformatf("sat_idle_ep%0d", ep), 32'(busy), 32'd0);
      check($sformatf("sat_highs_ep%0d", ep), 32'(highs), 32'd4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
